// File: rtl/fp8_pkg.sv
// Shared FP8/FP16 constants, operand/pipeline structs and the FP8 field decoder.
package fp8_pkg;

    localparam logic FP8_E4M3 = 1'b0;
    localparam logic FP8_E5M2 = 1'b1;

    localparam int E4M3_BIAS = 7;
    localparam int E5M2_BIAS = 15;
    localparam int FP16_BIAS = 15;

    localparam logic [15:0] FP16_QNAN = 16'h7E00;
    localparam logic [15:0] FP16_INF  = 16'h7C00;
    localparam logic [15:0] FP16_MAXF = 16'h7BFF;

    // Operand value = sig * 2^(exp - 3); E5M2 mantissas are left-aligned into sig.
    typedef struct packed {
        logic              sign;
        logic              zero;
        logic              inf;
        logic              nan;
        logic signed [5:0] exp;
        logic [3:0]        sig;
    } fp8_dec_t;

    // Product value = sig/128 * 2^exp, sig normalised with sig[7] = 1 unless zero.
    typedef struct packed {
        logic              sign;
        logic              zero;
        logic              inf;
        logic              nan;
        logic signed [7:0] exp;
        logic [7:0]        sig;
    } lane_s2_t;

    function automatic fp8_dec_t fp8_decode(input logic [7:0] x, input logic mode);
        fp8_dec_t   d;
        logic [4:0] e;
        logic [2:0] m;
        int         bias;
        d = '0;
        d.sign = x[7];
        if (mode == FP8_E5M2) begin
            e     = x[6:2];
            m     = {x[1:0], 1'b0};
            bias  = E5M2_BIAS;
            d.inf = (e == 5'd31) && (x[1:0] == 2'd0);
            d.nan = (e == 5'd31) && (x[1:0] != 2'd0);
        end else begin
            e     = {1'b0, x[6:3]};
            m     = x[2:0];
            bias  = E4M3_BIAS;
            d.inf = 1'b0;
            d.nan = (x[6:0] == 7'h7F);
        end
        d.zero = (e == 5'd0) && (m == 3'd0);
        d.sig  = {(e != 5'd0), m};
        // Subnormals share the exponent of the smallest normal.
        if (e == 5'd0) begin
            d.exp = 6'(1 - bias);
        end else begin
            d.exp = 6'(int'(e) - bias);
        end
        return d;
    endfunction

endpackage

// File: rtl/fp8_mul_lane.sv
// One FP8 x FP8 -> FP16 lane: decode (S1), multiply/normalise (S2), round/pack (S3).
// FP8_SATURATE_EN: overflow saturates to signed max-finite instead of signed inf.
module fp8_mul_lane
    import fp8_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic        i_mode,
    input  logic [7:0]  i_q,
    input  logic [7:0]  i_elem,
    output logic [15:0] o_res,
    output logic        o_ovf,
    output logic        o_unf,
    output logic        o_nan
);

    fp8_dec_t r_qd, r_ed;
    logic     r_mode;
    lane_s2_t w_s2, r_s2;

    logic [5:0]        w_p3;
    logic [7:0]        w_p4, w_prod, w_norm;
    logic [2:0]        w_pos;
    logic signed [8:0] w_bexp;
    logic [3:0]        w_sh;
    logic [21:0]       w_wide;
    logic [9:0]        w_mant;
    logic              w_g, w_st;
    logic [10:0]       w_rnd;
    logic [15:0]       w_res;
    logic              w_ovf, w_unf, w_nan;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_qd   <= '0;
            r_ed   <= '0;
            r_mode <= FP8_E4M3;
        end else if (i_en) begin
            r_qd   <= fp8_decode(i_q, i_mode);
            r_ed   <= fp8_decode(i_elem, i_mode);
            r_mode <= i_mode;
        end
    end

    always_comb begin
        w_p3 = {3'd0, r_qd.sig[3:1]} * {3'd0, r_ed.sig[3:1]};
        w_p4 = {4'd0, r_qd.sig} * {4'd0, r_ed.sig};
        // E5M2 carries only 3 significant bits; realign the 3x3 product.
        w_prod = (r_mode == FP8_E5M2) ? {w_p3, 2'b00} : w_p4;
        w_pos = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_prod[i]) w_pos = 3'(i);
        end
        w_norm = w_prod << (3'd7 - w_pos);
        w_s2 = '0;
        w_s2.sign = r_qd.sign ^ r_ed.sign;
        w_s2.zero = r_qd.zero | r_ed.zero;
        w_s2.inf  = r_qd.inf | r_ed.inf;
        w_s2.nan  = r_qd.nan | r_ed.nan | (r_qd.inf & r_ed.zero) | (r_qd.zero & r_ed.inf);
        w_s2.exp  = 8'(r_qd.exp) + 8'(r_ed.exp) + {5'd0, w_pos} - 8'd6;
        w_s2.sig  = w_norm;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s2 <= '0;
        end else if (i_en) begin
            r_s2 <= w_s2;
        end
    end

    always_comb begin
        w_res  = '0;
        w_ovf  = 1'b0;
        w_unf  = 1'b0;
        w_nan  = 1'b0;
        w_sh   = '0;
        w_wide = '0;
        w_mant = '0;
        w_g    = 1'b0;
        w_st   = 1'b0;
        w_rnd  = '0;
        w_bexp = 9'(r_s2.exp) + 9'(FP16_BIAS);
        if (r_s2.nan) begin
            w_res = FP16_QNAN;
            w_nan = 1'b1;
        end else if (r_s2.inf) begin
            w_res = {r_s2.sign, FP16_INF[14:0]};
        end else if (r_s2.zero) begin
            w_res = {r_s2.sign, 15'd0};
        end else if (w_bexp >= 9'sd31) begin
            w_ovf = 1'b1;
`ifdef FP8_SATURATE_EN
            w_res = {r_s2.sign, FP16_MAXF[14:0]};
`else
            w_res = {r_s2.sign, FP16_INF[14:0]};
`endif
        end else if (w_bexp >= 9'sd1) begin
            w_res = {r_s2.sign, w_bexp[4:0], r_s2.sig[6:0], 3'b000};
        end else begin
            // Shifts beyond 11 leave only sticky bits, same as 11.
            w_sh   = (w_bexp < -9'sd10) ? 4'd11 : 4'(-w_bexp);
            w_wide = {r_s2.sig, 14'd0} >> w_sh;
            w_mant = w_wide[21:12];
            w_g    = w_wide[11];
            w_st   = |w_wide[10:0];
            w_rnd  = {1'b0, w_mant} + {10'd0, w_g & (w_st | w_mant[0])};
            // A rounding carry lands in the exponent LSB, giving the smallest normal.
            w_res  = {r_s2.sign, 4'd0, w_rnd};
            w_unf  = w_g | w_st;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_res <= '0;
            o_ovf <= 1'b0;
            o_unf <= 1'b0;
            o_nan <= 1'b0;
        end else if (i_en) begin
            o_res <= w_res;
            o_ovf <= w_ovf;
            o_unf <= w_unf;
            o_nan <= w_nan;
        end
    end

endmodule

// File: rtl/fp8_vec_mul_pipe.sv
// Three-stage FP8 scalar x vector multiplier with valid/ready handshake, FP16 results.
// FP8_SATURATE_EN (in fp8_mul_lane): overflow saturates to max-finite.
module fp8_vec_mul_pipe
    import fp8_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 e5m2mode,
    input  logic [7:0]           q,
    input  logic [8*LANES-1:0]   vec,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [16*LANES-1:0]  res,
    output logic [LANES-1:0]     out_ovf,
    output logic [LANES-1:0]     out_unf,
    output logic [LANES-1:0]     out_nan
);

    logic [2:0] r_valid;
    logic       w_en;

    // Whole pipe advances together; bubbles are kept.
    assign w_en      = !r_valid[2] || out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_valid[2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
        end else if (w_en) begin
            r_valid <= {r_valid[1:0], in_valid};
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        fp8_mul_lane u_lane (
            .clk    (clk),
            .rst    (rst),
            .i_en   (w_en),
            .i_mode (e5m2mode),
            .i_q    (q),
            .i_elem (vec[8*g +: 8]),
            .o_res  (res[16*g +: 16]),
            .o_ovf  (out_ovf[g]),
            .o_unf  (out_unf[g]),
            .o_nan  (out_nan[g])
        );
    end

endmodule

// File: tb/tb_fp8_vec_mul_pipe.sv
// Directed bench for fp8_vec_mul_pipe (LANES = 4) with hand-computed FP16 results.
module tb_fp8_vec_mul_pipe;

    localparam int LANES = 4;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic                e5m2mode;
    logic [7:0]          q;
    logic [8*LANES-1:0]  vec;
    logic                out_valid;
    logic                out_ready;
    logic [16*LANES-1:0] res;
    logic [LANES-1:0]    out_ovf;
    logic [LANES-1:0]    out_unf;
    logic [LANES-1:0]    out_nan;

    int n_checks = 0;
    int n_errors = 0;

    fp8_vec_mul_pipe #(.LANES(LANES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .e5m2mode  (e5m2mode),
        .q         (q),
        .vec       (vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf),
        .out_nan   (out_nan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one transaction and waits (bounded) for its result; lat = -1 on timeout.
    task automatic run_txn(input logic mode, input logic [7:0] qi, input logic [31:0] vi,
                           output logic [63:0] r, output logic [11:0] fl, output int lat);
        @(negedge clk);
        out_ready = 1'b1;
        e5m2mode  = mode;
        q         = qi;
        vec       = vi;
        in_valid  = 1'b1;
        lat = -1;
        r   = 'x;
        fl  = 'x;
        for (int c = 1; c <= 10 && lat < 0; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                lat = c;
                r   = res;
                fl  = {out_ovf, out_unf, out_nan};
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; e5m2mode = 1'b0; q = '0; vec = '0;
        #12;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        n_checks++;
        if (res !== 64'h0) begin
            n_errors++; $display("FAIL reset_res: got %h want 0", res);
        end
        n_checks++;
        if ({out_ovf, out_unf, out_nan} !== 12'h000) begin
            n_errors++; $display("FAIL reset_flags: got %h want 000", {out_ovf, out_unf, out_nan});
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic [63:0] r; logic [11:0] fl; int lat;
        run_txn(1'b0, 8'h38, {4{8'h3C}}, r, fl, lat);
        n_checks++;
        if (lat !== 3) begin
            n_errors++; $display("FAIL basic_latency: got %0d want 3", lat);
        end
        n_checks++;
        if (r !== {4{16'h3E00}}) begin
            n_errors++; $display("FAIL basic_res: got %h want %h", r, {4{16'h3E00}});
        end
        n_checks++;
        if (fl !== 12'h000) begin
            n_errors++; $display("FAIL basic_flags: got %h want 000", fl);
        end
    endtask

    task automatic test_sign_exact();
        logic [63:0] r; logic [11:0] fl; int lat;
        run_txn(1'b0, 8'h3C, {8'h80, 8'h00, 8'h3C, 8'hB8}, r, fl, lat);
        n_checks++;
        if (r !== {16'h8000, 16'h0000, 16'h4080, 16'hBE00}) begin
            n_errors++; $display("FAIL sign_res: got %h want 8000000040 80be00", r);
        end
        n_checks++;
        if (fl !== 12'h000) begin
            n_errors++; $display("FAIL sign_flags: got %h want 000", fl);
        end
    endtask

    task automatic test_overflow_nan();
        logic [63:0] r; logic [11:0] fl; int lat; logic [63:0] exp_r;
`ifdef FP8_SATURATE_EN
        exp_r = {16'h4700, 16'hFBFF, 16'h7E00, 16'h7BFF};
`else
        exp_r = {16'h4700, 16'hFC00, 16'h7E00, 16'h7C00};
`endif
        run_txn(1'b0, 8'h7E, {8'h08, 8'hFE, 8'h7F, 8'h7E}, r, fl, lat);
        n_checks++;
        if (r !== exp_r) begin
            n_errors++; $display("FAIL ovf_res: got %h want %h", r, exp_r);
        end
        n_checks++;
        if (fl !== 12'h502) begin
            n_errors++; $display("FAIL ovf_flags: got %h want 502", fl);
        end
    endtask

    task automatic test_e5m2_underflow();
        logic [63:0] r; logic [11:0] fl; int lat;
        run_txn(1'b1, 8'h01, {8'h7C, 8'h3C, 8'h81, 8'h01}, r, fl, lat);
        n_checks++;
        if (r !== {16'h7C00, 16'h0100, 16'h8000, 16'h0000}) begin
            n_errors++; $display("FAIL unf_res: got %h want 7c00010080000000", r);
        end
        n_checks++;
        if (fl !== 12'h030) begin
            n_errors++; $display("FAIL unf_flags: got %h want 030", fl);
        end
    endtask

    task automatic test_specials();
        logic [63:0] r; logic [11:0] fl; int lat;
        run_txn(1'b1, 8'h00, {8'hBC, 8'h3C, 8'h7D, 8'h7C}, r, fl, lat);
        n_checks++;
        if (r !== {16'h8000, 16'h0000, 16'h7E00, 16'h7E00}) begin
            n_errors++; $display("FAIL special_res: got %h want 800000007e007e00", r);
        end
        n_checks++;
        if (fl !== 12'h003) begin
            n_errors++; $display("FAIL special_flags: got %h want 003", fl);
        end
    endtask

    // Subnormal results: tie-to-even down, inexact up, tie-to-even up, exact.
    task automatic test_subnormal_rne();
        logic [63:0] r; logic [11:0] fl; int lat;
        run_txn(1'b1, 8'h01, {8'h22, 8'h1E, 8'h1A, 8'h18}, r, fl, lat);
        n_checks++;
        if (r !== {16'h0003, 16'h0002, 16'h0001, 16'h0000}) begin
            n_errors++; $display("FAIL rne_res: got %h want 0003000200010000", r);
        end
        n_checks++;
        if (fl !== 12'h070) begin
            n_errors++; $display("FAIL rne_flags: got %h want 070", fl);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  q_t [6];
        logic [7:0]  e_t [6];
        logic [15:0] r_t [6];
        logic        held;
        logic [75:0] held_v;
        int          si, ri, extra;
        q_t = '{8'h38, 8'h3C, 8'h40, 8'h3C, 8'h38, 8'h44};
        e_t = '{8'h3C, 8'h40, 8'h48, 8'hC4, 8'h30, 8'h44};
        r_t = '{16'h3E00, 16'h4000, 16'h4800, 16'hC400, 16'h3800, 16'h4C00};
        si = 0; ri = 0; held = 1'b0; held_v = '0;
        for (int c = 0; c < 60 && ri < 6; c++) begin
            @(negedge clk);
            out_ready = !(c >= 5 && c < 9);
            #1;
            if (held) begin
                n_checks++;
                if (out_valid !== 1'b1 || {res, out_ovf, out_unf, out_nan} !== held_v) begin
                    n_errors++;
                    $display("FAIL stall_stable: got v=%b %h want v=1 %h", out_valid,
                             {res, out_ovf, out_unf, out_nan}, held_v);
                end
            end
            held = out_valid && !out_ready;
            if (held) held_v = {res, out_ovf, out_unf, out_nan};
            if (out_valid && out_ready) begin
                n_checks++;
                if ({res, out_ovf, out_unf, out_nan} !== {{4{r_t[ri]}}, 12'h000}) begin
                    n_errors++;
                    $display("FAIL stream_res[%0d]: got %h want %h", ri,
                             {res, out_ovf, out_unf, out_nan}, {{4{r_t[ri]}}, 12'h000});
                end
                ri++;
            end
            if (si < 6) begin
                in_valid = 1'b1;
                e5m2mode = si[0];
                q        = q_t[si];
                vec      = {4{e_t[si]}};
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && in_ready) si++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (ri !== 6) begin
            n_errors++; $display("FAIL stream_count: got %0d want 6", ri);
        end
        extra = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        n_checks++;
        if (extra !== 0) begin
            n_errors++; $display("FAIL stream_duplicates: got %0d want 0", extra);
        end
    endtask

    task automatic test_reset_midstream();
        logic [63:0] r; logic [11:0] fl; int lat;
        @(negedge clk);
        out_ready = 1'b1; e5m2mode = 1'b0; in_valid = 1'b1;
        q = 8'h38; vec = {4{8'h3C}};
        @(negedge clk);
        q = 8'h3C; vec = {4{8'hB8}};
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_errors++; $display("FAIL midrst_pre_valid: got %b want 1", out_valid);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || res !== 64'h0 || {out_ovf, out_unf, out_nan} !== 12'h000) begin
            n_errors++;
            $display("FAIL midrst_clear: got v=%b res=%h fl=%h want 0", out_valid, res,
                     {out_ovf, out_unf, out_nan});
        end
        @(posedge clk);
        #2;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++; $display("FAIL midrst_hold: got %b want 0", out_valid);
        end
        @(negedge clk);
        #1;
        rst = 1'b1;
        run_txn(1'b0, 8'h38, {8'h48, 8'h30, 8'h3C, 8'h38}, r, fl, lat);
        n_checks++;
        if (lat !== 3) begin
            n_errors++; $display("FAIL midrst_latency: got %0d want 3", lat);
        end
        n_checks++;
        if (r !== {16'h4400, 16'h3800, 16'h3E00, 16'h3C00}) begin
            n_errors++; $display("FAIL midrst_res: got %h want 440038003e003c00", r);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sign_exact();
        test_overflow_nan();
        test_e5m2_underflow();
        test_specials();
        test_subnormal_rne();
        test_back_to_back();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fp8_vec_mul_pipe.md
Name: fp8_vec_mul_pipe

Overview:
- Pipelined, parametrised FP8 scalar-by-vector multiplier: one FP8 scalar `q` times `LANES` FP8 elements, producing `LANES` IEEE FP16 products.
- Products are correctly rounded; specials and subnormals are handled exactly.
- Per-transaction E4M3/E5M2 mode and a valid/ready handshake on input and output.
- Feeds the systolic MAC array and replaces the single-cycle 4-lane multiplier in the tensor datapath.

Parameters:
- LANES, 4, number of vector elements per transaction (1..16).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept the input transaction.
- e5m2mode  in  1  1 = E5M2 (bias 15), 0 = E4M3 (bias 7, OCP FN: no inf, NaN = S.1111.111); captured with the data.
- q  in  8  FP8 scalar.
- vec  in  8*LANES  FP8 vector; lane i = vec[8i+7:8i].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- res  out  16*LANES  FP16 results; lane i = res[16i+15:16i].
- out_ovf  out  LANES  per-lane overflow flag.
- out_unf  out  LANES  per-lane underflow flag: tiny and inexact.
- out_nan  out  LANES  per-lane NaN-result flag.

Behaviour:
- Reset (rst low, asynchronous):
  - All stage valid bits clear; out_valid = 0.
  - res, out_ovf, out_unf, out_nan = 0.
  - in_ready = 1 once rst deasserts.
  - An in-flight transaction is discarded when reset asserts.
- Pipeline: 3 registered stages; latency is exactly 3 cycles from the accepting edge to out_valid with no backpressure.
  - S1: decode q and each element (sign, exponent, implicit bit, subnormal, zero, inf, NaN); register the fields and the mode.
  - S2: integer significand product (4x4 bits E4M3, 3x3 bits E5M2); unbiased exponent sum; leading-one normalise; register.
  - S3: rebias to FP16 (bias 15); overflow/underflow handling; round-to-nearest-even; pack and register to the outputs.
- Handshake:
  - Global enable en = !out_valid || out_ready; in_ready = en.
  - Transfer in on in_valid && in_ready; transfer out on out_valid && out_ready.
  - When en = 0, all stages hold. Bubbles are not compressed.
  - Sustained throughput is 1 transaction/cycle.
  - out_valid, res and flags are stable while out_valid && !out_ready.
  - Simultaneous out-transfer and in-transfer in the same cycle is legal and loses nothing.
- Arithmetic:
  - sign = q[7] ^ elem[7].
  - Products in the FP16 normal range are exact.
  - Results below 2^-14 are shifted into the FP16 subnormal range with RNE. Sticky covers all shifted-out bits.
  - Underflow to zero keeps the sign.
  - out_unf is set only when the result is inexact.
- Specials:
  - Zero × finite = signed zero.
  - E5M2 inf × nonzero finite = signed inf (0x7C00 or 0xFC00).
  - NaN in either operand, or inf × 0, gives canonical 0x7E00 with out_nan = 1.
- Overflow: result magnitude ≥ 65520 after rounding gives signed inf (0x7C00) with out_ovf = 1.
- Mode applies to q and all lanes of the transaction. A mode change between back-to-back transactions needs no idle cycle.

Optional Feature:
- FP8_SATURATE_EN defined:
  - Overflow gives signed max-finite (0x7BFF / 0xFBFF); out_ovf still set.
  - E5M2 inf operands still produce inf.
- FP8_SATURATE_EN undefined: overflow gives signed inf as specified above.

Decomposition:
- Package fp8_pkg:
  - Mode constants (FP8_E4M3 = 0, FP8_E5M2 = 1) and biases (7, 15, 15).
  - FP16_QNAN = 16'h7E00, FP16_INF = 16'h7C00, FP16_MAXF = 16'h7BFF.
  - Struct typedefs for the decoded operand and the S2 lane payload.
- Sub-module fp8_mul_lane: per-lane datapath with S1/S2/S3 registers and an enable input, instantiated LANES times.
- The handshake, valid pipeline and enable logic live in the top level.

Test Plan:
- E4M3, q = 8'h38 (1.0), all lanes 8'h3C (1.5) -> res lanes 16'h3E00, no flags, out_valid exactly 3 cycles after accept.
- E4M3, q = 8'h3C, lane 8'hB8 (−1.0) -> 16'hBE00. Lane 8'h3C -> 16'h4080 (2.25).
- E4M3, q = 8'h7E (448), lane 8'h7E -> 16'h7C00, out_ovf = 1; with FP8_SATURATE_EN -> 16'h7BFF. Lane 8'h7F (NaN) -> 16'h7E00, out_nan = 1.
- E5M2, q = 8'h01 (2^-16), lane 8'h01 -> 16'h0000, out_unf = 1. Lane 8'h7C (inf) with q = 8'h00 -> 16'h7E00, out_nan = 1.
- Backpressure:
  - Stream 6 back-to-back transactions with alternating mode, holding out_ready = 0 for 4 cycles mid-stream.
  - Results arrive in order, none dropped or duplicated, outputs stable while stalled.
- Reset mid-stream: assert rst asynchronously between clock edges with 2 transactions in flight -> out_valid drops immediately, outputs = 0, and the first post-reset transaction returns after 3 cycles.
